// File: rtl/matunmux_32.sv
// matunmux_32: recovers a = s - b over N signed lanes with one shared subtractor.
// Define MATUNMUX_SAT_EN to saturate overflowing lanes instead of wrapping.
module matunmux_32 #(
  parameter int N = 5,
  parameter int W = 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_in_valid,
  output logic           o_in_ready,
  input  logic [N*W-1:0] i_s,
  input  logic [N*W-1:0] i_b,
  output logic           o_out_valid,
  input  logic           i_out_ready,
  output logic [N*W-1:0] o_a,
  output logic           o_ovf
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t         r_state;
  logic [N*W-1:0] r_s;
  logic [N*W-1:0] r_b;
  logic [N*W-1:0] r_a;
  logic [IW-1:0]  r_idx;
  logic           r_ovf;
  logic           r_in_ready;
  logic           r_out_valid;

  logic [W-1:0]   w_sa;
  logic [W-1:0]   w_sb;
  logic [W-1:0]   w_diff;
  logic [W-1:0]   w_res;
  logic           w_ovf;

  always_comb begin
    w_sa = '0;
    w_sb = '0;
    for (int i = 0; i < N; i++) begin
      if (r_idx == IW'(i)) begin
        w_sa = r_s[i*W +: W];
        w_sb = r_b[i*W +: W];
      end
    end
  end

  assign w_diff = w_sa - w_sb;
  // Overflow only possible when operand signs differ.
  assign w_ovf  = (w_sa[W-1] != w_sb[W-1]) &&
                  (w_diff[W-1] != w_sa[W-1]);

`ifdef MATUNMUX_SAT_EN
  always_comb begin
    w_res = w_diff;
    if (w_ovf) begin
      if (w_sa[W-1]) w_res = {1'b1, {(W-1){1'b0}}};
      else           w_res = {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  assign w_res = w_diff;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_s         <= '0;
      r_b         <= '0;
      r_a         <= '0;
      r_idx       <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            r_s        <= i_s;
            r_b        <= i_b;
            r_idx      <= '0;
            r_ovf      <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= CALC;
          end
        end
        CALC: begin
          for (int i = 0; i < N; i++) begin
            if (r_idx == IW'(i)) r_a[i*W +: W] <= w_res;
          end
          r_ovf <= r_ovf | w_ovf;
          if (r_idx == IW'(N-1)) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_a         = r_a;
  assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_matunmux_32.sv
// tb_matunmux_32: randomized bench for matunmux_32 against a cycle-level
// behavioural model using wide integer arithmetic.
module tb_matunmux_32;
  localparam int N = 5;
  localparam int W = 32;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N*W-1:0] s = '0;
  logic [N*W-1:0] b = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [N*W-1:0] a;
  logic           ovf;

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_q[$];

  matunmux_32 #(.N(N), .W(W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_s(s), .i_b(b),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_a(a), .o_ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [N*W-1:0] act,
                     input logic [N*W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timeout got 0 want 1", nm);
  endtask

  function automatic void ref_lane(input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] r, output bit o);
    longint d;
    d = longint'($signed(x)) - longint'($signed(y));
    o = (d > MAXV) || (d < MINV);
`ifdef MATUNMUX_SAT_EN
    if (d > MAXV)      r = 32'h7FFFFFFF;
    else if (d < MINV) r = 32'h80000000;
    else               r = d[W-1:0];
`else
    r = d[W-1:0];
`endif
  endfunction

  // Behavioural model: accepted vector appears N edges later.
  bit           m_ready = 1'b1;
  bit           m_valid = 1'b0;
  bit           m_ovf = 1'b0;
  bit           p_ovf = 1'b0;
  int           m_cnt = 0;
  logic [W-1:0] m_a [N];
  logic [W-1:0] p_a [N];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready = 1'b1;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_cnt   = 0;
      for (int i = 0; i < N; i++) m_a[i] = '0;
    end else begin
      cyc++;
      if (m_ready && in_valid) begin
        m_ready = 1'b0;
        m_cnt   = N;
        p_ovf   = 1'b0;
        for (int i = 0; i < N; i++) begin
          bit o;
          ref_lane(s[i*W +: W], b[i*W +: W], p_a[i], o);
          p_ovf = p_ovf | o;
        end
        acc_q.push_back(cyc);
        n_vec++;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_valid = 1'b1;
          m_ovf   = p_ovf;
          for (int i = 0; i < N; i++) m_a[i] = p_a[i];
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
        m_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", {159'd0, in_ready}, {159'd0, m_ready});
    chk("out_valid", {159'd0, out_valid}, {159'd0, m_valid});
    if (m_valid) begin
      for (int i = 0; i < N; i++)
        chk($sformatf("a[%0d]", i), {128'd0, a[i*W +: W]}, {128'd0, m_a[i]});
      chk("ovf", {159'd0, ovf}, {159'd0, m_ovf});
    end
  end

  function automatic logic [N*W-1:0] pk(input int x0, input int x1, input int x2,
                                        input int x3, input int x4);
    return {x4, x3, x2, x1, x0};
  endfunction

  function automatic logic [W-1:0] rv();
    case ($urandom_range(0, 5))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [N*W-1:0] rvec();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = rv();
    return v;
  endfunction

  task automatic accept(input logic [N*W-1:0] vs, input logic [N*W-1:0] vb);
    int k = 0;
    s = vs;
    b = vb;
    in_valid = 1'b1;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) timeout("accept");
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    s = rvec();
    b = rvec();
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 50) timeout("out_valid");
  endtask

  logic [N*W-1:0] snap;
  int lat;
  int base;
  int nacc;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst a", a, '0);
    chk("rst in_ready", {159'd0, in_ready}, 160'd1);
    chk("rst out_valid", {159'd0, out_valid}, 160'd0);
    chk("rst ovf", {159'd0, ovf}, 160'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic inverse
    out_ready = 1'b1;
    accept(pk(10, 20, 30, 40, 50), pk(1, 2, 3, 4, 5));
    wait_done(lat);
    chk("latency", 160'(lat), 160'd5);
    chk("basic a", a, pk(9, 18, 27, 36, 45));
    chk("basic ovf", {159'd0, ovf}, 160'd0);
    @(negedge clk);
    chk("in_ready after hs", {159'd0, in_ready}, 160'd1);

    // Negative lanes
    accept(pk(-1, 0, -100, 7, 0), pk(1, -5, -100, -7, 0));
    wait_done(lat);
    chk("neg a", a, pk(-2, 5, 0, 14, 0));
    chk("neg ovf", {159'd0, ovf}, 160'd0);
    @(negedge clk);

    // Overflow on lane 2
    accept(pk(1, 2, 32'h7FFFFFFF, 4, 5), pk(0, 0, -1, 0, 0));
    wait_done(lat);
`ifdef MATUNMUX_SAT_EN
    chk("ovf a2", {128'd0, a[2*W +: W]}, 160'h7FFFFFFF);
`else
    chk("ovf a2", {128'd0, a[2*W +: W]}, 160'h80000000);
`endif
    chk("ovf flag", {159'd0, ovf}, 160'd1);
    @(negedge clk);

    // Backpressure in DONE
    out_ready = 1'b0;
    accept(pk(100, -200, 300, -400, 500), pk(7, 7, 7, 7, 7));
    wait_done(lat);
    snap = a;
    nacc = acc_q.size();
    repeat (10) begin
      @(negedge clk);
      in_valid = $urandom_range(0, 1);
      s = rvec();
    end
    chk("bp a stable", a, snap);
    chk("bp a", a, pk(93, -207, 293, -407, 493));
    chk("bp out_valid", {159'd0, out_valid}, 160'd1);
    chk("bp in_ready", {159'd0, in_ready}, 160'd0);
    chk("bp no accept", 160'(acc_q.size()), 160'(nacc));
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    // Reset after two CALC cycles
    accept(pk(11, 22, 33, 44, 55), pk(1, 1, 1, 1, 1));
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid rst a", a, '0);
    chk("mid rst out_valid", {159'd0, out_valid}, 160'd0);
    chk("mid rst in_ready", {159'd0, in_ready}, 160'd1);
    chk("mid rst ovf", {159'd0, ovf}, 160'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    accept(pk(5, 6, 7, 8, 9), pk(5, 5, 5, 5, 5));
    wait_done(lat);
    chk("post rst a", a, pk(0, 1, 2, 3, 4));
    @(negedge clk);

    // Back-to-back with in_valid and out_ready held high
    base = acc_q.size();
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (24) begin
      s = rvec();
      b = rvec();
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (acc_q.size() < base + 3) timeout("b2b accepts");
    else begin
      chk("b2b gap1", 160'(acc_q[base+1] - acc_q[base]), 160'd7);
      chk("b2b gap2", 160'(acc_q[base+2] - acc_q[base+1]), 160'd7);
    end
    repeat (12) @(negedge clk);

    // Randomized vectors with random output stalls
    for (int v = 0; v < 40; v++) begin
      out_ready = 1'b0;
      accept(rvec(), rvec());
      wait_done(lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
